sys_cfg_axil_bridge: RTL and testbench

AXI4-Lite slave that converts single-beat register transactions into accesses on the BRAM-style port of the system configuration register block (bram_en/bram_we/bram_addr/bram_din/bram_dout). It sits directly upstream of the cfg register wrapper and replaces the AXI BRAM controller IP for the cfg path. It handles one outstanding transaction at a time, arbitrates reads and writes round-robin, and optionally returns DECERR for out-of-range addresses.

---
 rtl/sys_cfg_axil_bridge_if.sv | 35 +++
 rtl/sys_cfg_axil_bridge.sv | 141 ++++++++++++++
 tb/tb_sys_cfg_axil_bridge.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cfg_axil_bridge_if.sv
// AXI4-Lite channel bundle between an AXI master and the cfg-path bridge.
// The master modport is the interconnect side; the slave modport is the bridge side.
interface sys_cfg_axil_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_NUM   = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BYTE_NUM-1:0]   wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sys_cfg_axil_bridge.sv
// AXI4-Lite slave to BRAM-style port bridge for the system cfg register block.
// Optional macro CFG_AXIL_DECERR_EN: out-of-range addresses skip the BRAM and answer DECERR.
module sys_cfg_axil_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_NUM   = 4,
  parameter int REG_NUM    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  sys_cfg_axil_bridge_if.slave  s_axi,
  output logic                  bram_en,
  output logic [BYTE_NUM-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] REG_BYTES = ADDR_WIDTH'(REG_NUM * BYTE_NUM);

`ifdef CFG_AXIL_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RWAIT, RRESP} state_t;

  state_t                state;
  state_t                state_next;
  logic                  last_read;
  logic                  dec_err;
  logic [BYTE_NUM-1:0]   wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;
  logic                  wr_cand;
  logic                  rd_cand;
  logic                  grant_wr;
  logic                  grant_rd;
  logic [ADDR_WIDTH-1:0] grant_addr;

  // A write needs AW and W together; on a tie the type not served last wins.
  always_comb begin
    wr_cand    = s_axi.awvalid && s_axi.wvalid;
    rd_cand    = s_axi.arvalid;
    grant_wr   = rstn && wr_cand && (!rd_cand || last_read);
    grant_rd   = rstn && rd_cand && (!wr_cand || !last_read);
    grant_addr = grant_wr ? s_axi.awaddr : s_axi.araddr;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.rvalid  = 1'b0;
    bram_en       = 1'b0;
    bram_we       = '0;
    case (state)
      IDLE: begin
        if (grant_wr) begin
          s_axi.awready = 1'b1;
          s_axi.wready  = 1'b1;
          state_next    = WR;
        end else if (grant_rd) begin
          s_axi.arready = 1'b1;
          state_next    = RD;
        end
      end
      WR: begin
        if (!dec_err) begin
          bram_en = 1'b1;
          bram_we = wstrb_q;
        end
        state_next = WRESP;
      end
      WRESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) state_next = IDLE;
      end
      RD: begin
        bram_en    = !dec_err;
        state_next = RWAIT;
      end
      RWAIT: state_next = RRESP;
      RRESP: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once at grant; BRAM read data lands during RWAIT.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_read <= 1'b1;
      dec_err   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (state == IDLE && (grant_wr || grant_rd)) begin
        last_read <= grant_rd;
        bram_addr <= {grant_addr[ADDR_WIDTH-1:2], 2'b00};
        dec_err   <= DECERR_EN && (grant_addr >= REG_BYTES);
      end
      if (state == IDLE && grant_wr) begin
        bram_din <= s_axi.wdata;
        wstrb_q  <= s_axi.wstrb;
      end
      if (state == WR) begin
        bresp_q <= dec_err ? RESP_DECERR : RESP_OKAY;
      end
      if (state == RWAIT) begin
        rdata_q <= dec_err ? '0 : bram_dout;
        rresp_q <= dec_err ? RESP_DECERR : RESP_OKAY;
      end
    end
  end

  assign s_axi.bresp = bresp_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rdata = rdata_q;

endmodule

// File: tb/tb_sys_cfg_axil_bridge.sv
// Directed bench for sys_cfg_axil_bridge with a registered-output BRAM model.
// Expectations follow CFG_AXIL_DECERR_EN when the build defines it.
module tb_sys_cfg_axil_bridge;

  logic        clk;
  logic        rstn;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic [31:0] mem [16];

  int checks;
  int errors;

`ifdef CFG_AXIL_DECERR_EN
  localparam logic        EXP_OOR_EN    = 1'b0;
  localparam logic [3:0]  EXP_OOR_WE    = 4'h0;
  localparam logic [1:0]  EXP_OOR_RESP  = 2'b11;
  localparam logic [31:0] EXP_OOR_RDATA = 32'h0000_0000;
`else
  localparam logic        EXP_OOR_EN    = 1'b1;
  localparam logic [3:0]  EXP_OOR_WE    = 4'hF;
  localparam logic [1:0]  EXP_OOR_RESP  = 2'b00;
  localparam logic [31:0] EXP_OOR_RDATA = 32'hCAFE_F00D;
`endif

  sys_cfg_axil_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_NUM(4)) axi ();

  sys_cfg_axil_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_NUM(4), .REG_NUM(4)
  ) dut (
    .clk(clk), .rstn(rstn), .s_axi(axi),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM with byte enables and one-cycle registered read data.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    bram_dout = 32'h0;
  end

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we == 4'h0) begin
        bram_dout <= mem[bram_addr[5:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bram_we[b]) mem[bram_addr[5:2]][b*8 +: 8] <= bram_din[b*8 +: 8];
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({axi.awready, axi.wready, axi.arready} !== 3'b000) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 000", {axi.awready, axi.wready, axi.arready}); end
    checks++; if ({axi.bvalid, axi.rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 00", {axi.bvalid, axi.rvalid}); end
    checks++; if ({bram_en, bram_we} !== 5'h0) begin errors++; $display("[TB] FAIL rst_bram_en_we: got %h expected 0", {bram_en, bram_we}); end
    checks++; if ({bram_addr, bram_din} !== 64'h0) begin errors++; $display("[TB] FAIL rst_bram_addr_din: got %h expected 0", {bram_addr, bram_din}); end
    checks++; if ({axi.rdata, axi.bresp, axi.rresp} !== 36'h0) begin errors++; $display("[TB] FAIL rst_resp: got %h expected 0", {axi.rdata, axi.bresp, axi.rresp}); end
    rstn = 1'b1;
  endtask

  task automatic test_write();
    @(negedge clk);
    axi.awaddr = 32'h4; axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    #1;
    checks++; if ({axi.awready, axi.wready} !== 2'b11) begin errors++; $display("[TB] FAIL wr_grant: got %b expected 11", {axi.awready, axi.wready}); end
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    #1;
    checks++; if ({bram_en, bram_we} !== 5'h1F) begin errors++; $display("[TB] FAIL wr_bram_en_we: got %h expected 1f", {bram_en, bram_we}); end
    checks++; if (bram_addr !== 32'h4) begin errors++; $display("[TB] FAIL wr_bram_addr: got %h expected 00000004", bram_addr); end
    checks++; if (bram_din !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_bram_din: got %h expected deadbeef", bram_din); end
    checks++; if ({axi.bvalid, axi.awready} !== 2'b00) begin errors++; $display("[TB] FAIL wr_early_bvalid: got %b expected 00", {axi.bvalid, axi.awready}); end
    @(negedge clk); #1;
    checks++; if ({axi.bvalid, axi.bresp} !== 3'b100) begin errors++; $display("[TB] FAIL wr_bresp: got %b expected 100", {axi.bvalid, axi.bresp}); end
    checks++; if ({bram_en, bram_we} !== 5'h0) begin errors++; $display("[TB] FAIL wr_bram_idle: got %h expected 0", {bram_en, bram_we}); end
    @(negedge clk); #1;
    checks++; if (axi.bvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_bvalid_drop: got %b expected 0", axi.bvalid); end
  endtask

  task automatic test_read();
    @(negedge clk);
    axi.araddr = 32'h4; axi.arvalid = 1'b1; axi.rready = 1'b1;
    #1;
    checks++; if (axi.arready !== 1'b1) begin errors++; $display("[TB] FAIL rd_grant: got %b expected 1", axi.arready); end
    @(negedge clk);
    axi.arvalid = 1'b0;
    #1;
    checks++; if ({bram_en, bram_we} !== 5'h10) begin errors++; $display("[TB] FAIL rd_bram_en_we: got %h expected 10", {bram_en, bram_we}); end
    checks++; if (bram_addr !== 32'h4) begin errors++; $display("[TB] FAIL rd_bram_addr: got %h expected 00000004", bram_addr); end
    @(negedge clk); #1;
    checks++; if ({bram_en, axi.rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL rd_wait: got %b expected 00", {bram_en, axi.rvalid}); end
    @(negedge clk); #1;
    checks++; if ({axi.rvalid, axi.rresp} !== 3'b100) begin errors++; $display("[TB] FAIL rd_rresp: got %b expected 100", {axi.rvalid, axi.rresp}); end
    checks++; if (axi.rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_rdata: got %h expected deadbeef", axi.rdata); end
    @(negedge clk); #1;
    checks++; if (axi.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_rvalid_drop: got %b expected 0", axi.rvalid); end
  endtask

  task automatic test_aw_without_w();
    @(negedge clk);
    axi.awaddr = 32'h9; axi.wdata = 32'h1234_5678; axi.wstrb = 4'h3;
    axi.awvalid = 1'b1; axi.wvalid = 1'b0; axi.bready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({axi.awready, axi.wready, bram_en} !== 3'b000) begin errors++; $display("[TB] FAIL aw_alone_%0d: got %b expected 000", i, {axi.awready, axi.wready, bram_en}); end
      @(negedge clk);
    end
    axi.wvalid = 1'b1;
    #1;
    checks++; if ({axi.awready, axi.wready} !== 2'b11) begin errors++; $display("[TB] FAIL aw_w_grant: got %b expected 11", {axi.awready, axi.wready}); end
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    #1;
    checks++; if ({bram_en, bram_we} !== 5'h13) begin errors++; $display("[TB] FAIL aw_w_bram_we: got %h expected 13", {bram_en, bram_we}); end
    checks++; if (bram_addr !== 32'h8) begin errors++; $display("[TB] FAIL aw_w_bram_addr: got %h expected 00000008", bram_addr); end
    @(negedge clk); #1;
    checks++; if ({axi.bvalid, axi.bresp} !== 3'b100) begin errors++; $display("[TB] FAIL aw_w_bresp: got %b expected 100", {axi.bvalid, axi.bresp}); end
    @(negedge clk);
  endtask

  task automatic test_rresp_stall();
    @(negedge clk);
    axi.araddr = 32'h8; axi.arvalid = 1'b1; axi.rready = 1'b0;
    #1;
    checks++; if (axi.arready !== 1'b1) begin errors++; $display("[TB] FAIL stall_grant: got %b expected 1", axi.arready); end
    @(negedge clk);
    axi.araddr = 32'h4;
    #1;
    checks++; if (axi.arready !== 1'b0) begin errors++; $display("[TB] FAIL stall_busy_arready: got %b expected 0", axi.arready); end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if ({axi.rvalid, axi.arready, axi.rdata} !== {2'b10, 32'h0000_5678}) begin errors++; $display("[TB] FAIL stall_hold_%0d: got %b/%b/%h expected 1/0/00005678", i, axi.rvalid, axi.arready, axi.rdata); end
      @(negedge clk);
    end
    axi.rready = 1'b1;
    #1;
    checks++; if (axi.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_rvalid: got %b expected 1", axi.rvalid); end
    @(negedge clk); #1;
    checks++; if ({axi.rvalid, axi.arready} !== 2'b01) begin errors++; $display("[TB] FAIL stall_next_grant: got %b expected 01", {axi.rvalid, axi.arready}); end
    @(negedge clk);
    axi.arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if ({axi.rvalid, axi.rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL stall_second_read: got %b/%h expected 1/deadbeef", axi.rvalid, axi.rdata); end
    @(negedge clk);
  endtask

  task automatic test_decerr();
    @(negedge clk);
    axi.awaddr = 32'h10; axi.wdata = 32'hCAFE_F00D; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    #1;
    checks++; if (axi.awready !== 1'b1) begin errors++; $display("[TB] FAIL oor_wr_grant: got %b expected 1", axi.awready); end
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    #1;
    checks++; if ({bram_en, bram_we} !== {EXP_OOR_EN, EXP_OOR_WE}) begin errors++; $display("[TB] FAIL oor_wr_bram: got %h expected %h", {bram_en, bram_we}, {EXP_OOR_EN, EXP_OOR_WE}); end
    @(negedge clk); #1;
    checks++; if ({axi.bvalid, axi.bresp} !== {1'b1, EXP_OOR_RESP}) begin errors++; $display("[TB] FAIL oor_bresp: got %b expected %b", {axi.bvalid, axi.bresp}, {1'b1, EXP_OOR_RESP}); end
    @(negedge clk);
    axi.araddr = 32'h10; axi.arvalid = 1'b1; axi.rready = 1'b1;
    #1;
    checks++; if (axi.arready !== 1'b1) begin errors++; $display("[TB] FAIL oor_rd_grant: got %b expected 1", axi.arready); end
    @(negedge clk);
    axi.arvalid = 1'b0;
    #1;
    checks++; if (bram_en !== EXP_OOR_EN) begin errors++; $display("[TB] FAIL oor_rd_bram_en: got %b expected %b", bram_en, EXP_OOR_EN); end
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if ({axi.rvalid, axi.rresp} !== {1'b1, EXP_OOR_RESP}) begin errors++; $display("[TB] FAIL oor_rresp: got %b expected %b", {axi.rvalid, axi.rresp}, {1'b1, EXP_OOR_RESP}); end
    checks++; if (axi.rdata !== EXP_OOR_RDATA) begin errors++; $display("[TB] FAIL oor_rdata: got %h expected %h", axi.rdata, EXP_OOR_RDATA); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int grant_cycle[$];
    bit grant_read[$];
    int exp_cycle[6] = '{0, 3, 7, 10, 14, 17};
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    axi.awaddr = 32'hC; axi.wdata = 32'h0BAD_F00D; axi.wstrb = 4'hF; axi.araddr = 32'hC;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    axi.bready = 1'b1; axi.rready = 1'b1;
    for (int cyc = 0; cyc < 40 && grant_cycle.size() < 6; cyc++) begin
      #1;
      if (axi.awready && axi.arready) begin
        checks++; errors++;
        $display("[TB] FAIL b2b_dual_grant: got both readies at cycle %0d expected one", cyc);
      end
      if (axi.awready) begin grant_cycle.push_back(cyc); grant_read.push_back(1'b0); end
      else if (axi.arready) begin grant_cycle.push_back(cyc); grant_read.push_back(1'b1); end
      @(negedge clk);
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    checks++; if (grant_cycle.size() !== 6) begin errors++; $display("[TB] FAIL b2b_grant_count: got %0d expected 6", grant_cycle.size()); end
    for (int i = 0; i < grant_cycle.size(); i++) begin
      checks++; if (grant_read[i] !== bit'(i % 2)) begin errors++; $display("[TB] FAIL b2b_order_%0d: got read=%0b expected read=%0b", i, grant_read[i], i % 2); end
      checks++; if (grant_cycle[i] !== exp_cycle[i]) begin errors++; $display("[TB] FAIL b2b_cycle_%0d: got %0d expected %0d", i, grant_cycle[i], exp_cycle[i]); end
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_aw_without_w();
    test_rresp_stall();
    test_decerr();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
